// File: rtl/simon_seq_if.sv
// Command/status bundle for simon_sequence. With SIMON_SEQ_STIR_EN defined the
// bundle also carries the stir request.
interface simon_seq_if;
  logic       clear;
  logic       append;
  logic       rewind;
  logic       step;
`ifdef SIMON_SEQ_STIR_EN
  logic       stir;
`endif
  logic [1:0] color;
  logic [6:0] length;
  logic [5:0] index;
  logic       empty;
  logic       full;
  logic       at_end;

`ifdef SIMON_SEQ_STIR_EN
  modport master (output clear, append, rewind, step, stir,
                  input  color, length, index, empty, full, at_end);
  modport slave  (input  clear, append, rewind, step, stir,
                  output color, length, index, empty, full, at_end);
`else
  modport master (output clear, append, rewind, step,
                  input  color, length, index, empty, full, at_end);
  modport slave  (input  clear, append, rewind, step,
                  output color, length, index, empty, full, at_end);
`endif
endinterface

// File: rtl/simon_sequence.sv
// Simon colour sequence store: 64 x 2-bit entries filled from a free-running LFSR.
// Optional feature macro SIMON_SEQ_STIR_EN adds the stir input (double LFSR rate).
module simon_sequence (
  input  logic          clk,
  input  logic          reset,
  simon_seq_if.slave    bus
);
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [6:0]  DEPTH     = 7'd64;

  logic [63:0][1:0] mem;
  logic [6:0]       length_q;
  logic [5:0]       index_q;
  logic [15:0]      lfsr;
  logic [15:0]      lfsr_next;
  logic             is_full;
  logic             can_step;

  // Fibonacci taps 16,14,13,11 map to bits 0,2,3,5 in this right-shifting form.
  function automatic logic [15:0] lfsr_shift(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

  always_comb begin
    lfsr_next = lfsr_shift(lfsr);
`ifdef SIMON_SEQ_STIR_EN
    if (bus.stir) lfsr_next = lfsr_shift(lfsr_next);
`endif
  end

  assign is_full  = (length_q == DEPTH);
  assign can_step = (length_q != 7'd0) && (({1'b0, index_q} + 7'd1) < length_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      length_q <= 7'd0;
      index_q  <= 6'd0;
      lfsr     <= LFSR_SEED;
      mem      <= '0;
    end else begin
      lfsr <= lfsr_next;
      if (bus.clear) begin
        length_q <= 7'd0;
        index_q  <= 6'd0;
      end else begin
        // Step decision uses the pre-append length, so append is evaluated independently.
        if (bus.append && !is_full) begin
          mem[length_q[5:0]] <= lfsr[1:0];
          length_q           <= length_q + 7'd1;
        end
        if (bus.rewind)
          index_q <= 6'd0;
        else if (bus.step && can_step)
          index_q <= index_q + 6'd1;
      end
    end
  end

  assign bus.color  = mem[index_q];
  assign bus.length = length_q;
  assign bus.index  = index_q;
  assign bus.empty  = (length_q == 7'd0);
  assign bus.full   = is_full;
  assign bus.at_end = (length_q != 7'd0) && ({1'b0, index_q} == (length_q - 7'd1));

endmodule
